// File: rtl/mont_mult_arbiter_pkg.sv
// Shared constants and state encoding for the Montgomery multiplier arbiter.
package mont_mult_arbiter_pkg;

    localparam int unsigned W_FIELD         = 381;
    localparam int unsigned TIMEOUT_DEFAULT = 4095;
    localparam int unsigned WD_W            = 16;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_START   = 3'd1,
        ARB_WAIT    = 3'd2,
        ARB_RESP    = 3'd3,
        ARB_RELEASE = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mont_mult_arbiter_if.sv
// Requester and multiplier-core signals of the arbiter; slave is the arbiter side,
// master is the requester/core side.
interface mont_mult_arbiter_if
    import mont_mult_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = W_FIELD
) ();
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [W-1:0]         modulus;
    logic [NUM_REQ-1:0]   rsp_done;
    logic                 rsp_err;
    logic [W-1:0]         rsp_result;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic                 mm_start;
    logic [W-1:0]         mm_a;
    logic [W-1:0]         mm_b;
    logic [W-1:0]         mm_m;
    logic                 mm_done;
    logic [W-1:0]         mm_result;

    modport slave (
        input  req, req_a, req_b, modulus, mm_done, mm_result,
        output rsp_done, rsp_err, rsp_result, busy, grant_id,
               mm_start, mm_a, mm_b, mm_m
    );

    modport master (
        output req, req_a, req_b, modulus, mm_done, mm_result,
        input  rsp_done, rsp_err, rsp_result, busy, grant_id,
               mm_start, mm_a, mm_b, mm_m
    );

endinterface

// File: rtl/mont_mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NUM_REQ.
module rr_pick
    import mont_mult_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    output logic               valid_o,
    output logic [IDW-1:0]     winner_o
);

    logic [IDW-1:0] idx;

    // Walk from the farthest offset down so the nearest requester is written last.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int off = int'(NUM_REQ); off >= 1; off--) begin
            idx = IDW'((int'(last_i) + off) % int'(NUM_REQ));
            if (req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/mont_mult_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier core between NUM_REQ requesters,
// with a watchdog that aborts a hung multiplication.
module mont_mult_arbiter
    import mont_mult_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = W_FIELD,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic                clk,
    input logic                reset,
    mont_mult_arbiter_if.slave bus
);

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic               mm_start_q, mm_start_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] rsp_done_q, rsp_done_d;
    logic               rsp_err_q, rsp_err_d;
    logic [W-1:0]       rsp_result_q, rsp_result_d;
    logic [W-1:0]       mm_a_q, mm_a_d;
    logic [W-1:0]       mm_b_q, mm_b_d;
    logic [W-1:0]       mm_m_q, mm_m_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic               pick_valid;
    logic [IDW-1:0]     pick_winner;
    logic [W-1:0]       a_arr [NUM_REQ];
    logic [W-1:0]       b_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign a_arr[g] = bus.req_a[g*W +: W];
        assign b_arr[g] = bus.req_b[g*W +: W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .req_i    (bus.req),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_d      = grant_q;
        rsp_err_d    = rsp_err_q;
        rsp_result_d = rsp_result_q;
        mm_a_d       = mm_a_q;
        mm_b_d       = mm_b_q;
        mm_m_d       = mm_m_q;
        wd_d         = wd_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_START;
                    last_d  = pick_winner;
                    grant_d = pick_winner;
                    mm_a_d  = a_arr[pick_winner];
                    mm_b_d  = b_arr[pick_winner];
                    mm_m_d  = bus.modulus;
                end
            end
            ARB_START: begin
                state_d = ARB_WAIT;
                wd_d    = '0;
            end
            ARB_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // A done arriving together with the timeout still counts as success.
                if (bus.mm_done) begin
                    state_d      = ARB_RESP;
                    rsp_result_d = bus.mm_result;
                    rsp_err_d    = 1'b0;
                end else if (wd_q == WD_W'(TIMEOUT)) begin
                    state_d      = ARB_RESP;
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                end
            end
            ARB_RESP:    state_d = ARB_RELEASE;
            ARB_RELEASE: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase

        mm_start_d = (state_d == ARB_START);
        busy_d     = (state_d != ARB_IDLE);
        rsp_done_d = '0;
        if (state_d == ARB_RESP) begin
            rsp_done_d[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_q       <= IDW'(NUM_REQ - 1);
            grant_q      <= '0;
            mm_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            rsp_done_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            mm_a_q       <= '0;
            mm_b_q       <= '0;
            mm_m_q       <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            mm_start_q   <= mm_start_d;
            busy_q       <= busy_d;
            rsp_done_q   <= rsp_done_d;
            rsp_err_q    <= rsp_err_d;
            rsp_result_q <= rsp_result_d;
            mm_a_q       <= mm_a_d;
            mm_b_q       <= mm_b_d;
            mm_m_q       <= mm_m_d;
            wd_q         <= wd_d;
        end
    end

    assign bus.rsp_done   = rsp_done_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_q;
    assign bus.mm_start   = mm_start_q;
    assign bus.mm_a       = mm_a_q;
    assign bus.mm_b       = mm_b_q;
    assign bus.mm_m       = mm_m_q;

endmodule
